// File: rtl/mem_responder_if.sv
// Request/response bundle between an initiator and the mem_responder word memory.
interface mem_responder_if;
    logic        mem_addr_valid;
    logic [31:0] mem_addr;
    logic        mem_data_valid;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [31:0] mem_input;
    logic        mem_error;
    logic        busy;
    logic [31:0] req_count;

    modport slave (
        input  mem_addr_valid, mem_addr, mem_data_valid, mem_data,
        output mem_ready, mem_input, mem_error, busy, req_count
    );

    modport master (
        output mem_addr_valid, mem_addr, mem_data_valid, mem_data,
        input  mem_ready, mem_input, mem_error, busy, req_count
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then answers with a one-cycle mem_ready strobe.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input logic           clk,
    input logic           reset,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state, w_nextState;
    logic [3:0]  r_cnt, w_nextCnt;
    logic [31:0] r_addr, r_data;
    logic        r_we;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic        r_ready, r_error, r_busy;
    logic [31:0] r_input, r_count;

    logic          w_accept, w_enterResp, w_we, w_bad;
    logic [31:0]   w_addr, w_data;
    logic [AW-1:0] w_idx;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_accept    = 1'b0;
        w_enterResp = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_addr_valid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_nextState = RESP;
                        w_enterResp = 1'b1;
                    end else begin
                        w_nextState = WAIT;
                        w_nextCnt   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_nextState = RESP;
                    w_enterResp = 1'b1;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // With LATENCY=0 the response is produced on the accepting edge, so the
    // live inputs stand in for the not-yet-latched request.
    always_comb begin
        w_addr = (r_state == IDLE) ? bus.mem_addr       : r_addr;
        w_data = (r_state == IDLE) ? bus.mem_data       : r_data;
        w_we   = (r_state == IDLE) ? bus.mem_data_valid : r_we;
        w_bad  = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH_WORDS));
        w_idx  = w_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_input <= 32'd0;
            r_count <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_busy  <= (w_nextState != IDLE);
            r_ready <= w_enterResp;
            r_error <= w_enterResp && w_bad;
            if (w_accept) begin
                r_addr <= bus.mem_addr;
                r_data <= bus.mem_data;
                r_we   <= bus.mem_data_valid;
            end
            if (w_enterResp) begin
                r_count <= r_count + 32'd1;
                if (w_bad)
                    r_input <= 32'd0;
                else if (w_we)
                    r_input <= w_data;
                else
                    r_input <= r_mem[w_idx];
            end
        end
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && w_enterResp && w_we && !w_bad)
            r_mem[w_idx] <= w_data;
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_error = r_error;
    assign bus.mem_input = r_input;
    assign bus.busy      = r_busy;
    assign bus.req_count = r_count;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the stimulus side predicts each response
// from a word-array model, a negedge monitor compares what the DUT presents.
module tb_mem_responder;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;

    typedef struct {
        int          respEdge;
        logic [31:0] data;
        logic        err;
        logic [31:0] count;
        logic        isWrite;
        int          idx;
        logic [31:0] oldVal;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mem_responder_if busIf();

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    int          edgeNum = 0;
    int          checks = 0;
    int          errors = 0;
    int          nextAccept = 0;
    int          busyFrom = 1;
    int          busyTo = 0;
    bit          monOn = 0;
    logic [31:0] modelMem [DEPTH];
    logic [31:0] modelCount = 0;
    logic [31:0] lastData = 0;
    exp_t        expQ[$];
    exp_t        monEntry;

    always @(posedge clk) edgeNum <= edgeNum + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edgeNum, actual, expected);
        end
    endtask

    function automatic logic [31:0] randAddr();
        int r = $urandom_range(0, 9);
        if (r == 0)
            return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else if (r == 1)
            return ($urandom_range(0, 1) == 1) ? (32'(4 * DEPTH) + ($urandom & 32'h0000_FFFC))
                                               : ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        else
            return 32'($urandom_range(0, DEPTH - 1)) << 2;
    endfunction

    // Reference behaviour of one accepted request, evaluated at acceptance.
    task automatic modelAccept(input int e, input logic [31:0] addr, input logic wr, input logic [31:0] data);
        exp_t        ent;
        logic [29:0] wordIdx = addr[31:2];
        bit          bad = (addr[1:0] != 2'b00) || (int'(wordIdx) >= DEPTH) || (wordIdx[29] == 1'b1);
        modelCount   = modelCount + 32'd1;
        ent.respEdge = e + LAT;
        ent.count    = modelCount;
        ent.err      = bad;
        ent.isWrite  = wr;
        ent.idx      = 0;
        ent.oldVal   = 32'd0;
        ent.data     = 32'd0;
        if (!bad) begin
            ent.idx = int'(wordIdx);
            ent.oldVal = modelMem[ent.idx];
            if (wr) begin
                modelMem[ent.idx] = data;
                ent.data = data;
            end else begin
                ent.data = modelMem[ent.idx];
            end
        end
        expQ.push_back(ent);
        nextAccept = e + LAT + 2;
        busyFrom   = e;
        busyTo     = e + LAT;
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic wr, input logic [31:0] data);
        int e = edgeNum + 1;
        busIf.mem_addr_valid = valid;
        busIf.mem_addr       = addr;
        busIf.mem_data_valid = wr;
        busIf.mem_data       = data;
        if (valid && !reset && e >= nextAccept)
            modelAccept(e, addr, wr, data);
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic wr, input logic [31:0] data);
        while (edgeNum + 1 < nextAccept)
            applyStimulus(1'b0, randAddr(), 1'($urandom_range(0, 1)), $urandom);
        applyStimulus(1'b1, addr, wr, data);
    endtask

    // Aborted requests never touch the array, so undo their model effects.
    task automatic clearModel();
        exp_t ent;
        while (expQ.size() > 0) begin
            ent = expQ.pop_back();
            if (ent.isWrite && !ent.err)
                modelMem[ent.idx] = ent.oldVal;
        end
        modelCount = 0;
        lastData   = 0;
        busyFrom   = 1;
        busyTo     = 0;
    endtask

    task automatic doReset(input int n);
        busIf.mem_addr_valid = 1'b1;
        busIf.mem_addr       = 32'h0000_0008;
        busIf.mem_data_valid = 1'b1;
        busIf.mem_data       = $urandom;
        reset = 1'b1;
        @(posedge clk);
        #1;
        clearModel();
        monOn = 1;
        checkOutput("resetReady", 32'(busIf.mem_ready), 32'd0);
        checkOutput("resetError", 32'(busIf.mem_error), 32'd0);
        checkOutput("resetInput", busIf.mem_input, 32'd0);
        checkOutput("resetCount", busIf.req_count, 32'd0);
        checkOutput("resetBusy", 32'(busIf.busy), 32'd0);
        repeat (n - 1) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        busIf.mem_addr_valid = 1'b0;
        nextAccept = edgeNum + 1;
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            checkOutput("busy", 32'(busIf.busy), 32'(edgeNum >= busyFrom && edgeNum <= busyTo));
            while (expQ.size() > 0 && expQ[0].respEdge < edgeNum) begin
                checkOutput("respMissingEdge", 32'(edgeNum), 32'(expQ[0].respEdge));
                void'(expQ.pop_front());
            end
            if (busIf.mem_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousReady", 32'(busIf.mem_ready), 32'd0);
                end else begin
                    monEntry = expQ.pop_front();
                    checkOutput("respEdge", 32'(edgeNum), 32'(monEntry.respEdge));
                    checkOutput("respData", busIf.mem_input, monEntry.data);
                    checkOutput("respError", 32'(busIf.mem_error), 32'(monEntry.err));
                    checkOutput("respCount", busIf.req_count, monEntry.count);
                    lastData = monEntry.data;
                end
            end else begin
                checkOutput("idleError", 32'(busIf.mem_error), 32'd0);
                checkOutput("heldInput", busIf.mem_input, lastData);
            end
        end
    end

    initial begin
        busIf.mem_addr_valid = 1'b0;
        busIf.mem_addr       = 32'd0;
        busIf.mem_data_valid = 1'b0;
        busIf.mem_data       = 32'd0;
        doReset(3);

        for (int i = 0; i < DEPTH; i++)
            request(32'(i) << 2, 1'b1, $urandom);

        request(32'h0000_0004, 1'b1, 32'hDEAD_BEEF);
        request(32'h0000_0004, 1'b0, 32'h0);
        request(32'h0000_0010, 1'b1, 32'h1234_5678);
        request(32'h0000_0010, 1'b0, 32'h0);

        request(32'h0000_0002, 1'b0, 32'h0);
        request(32'(4 * DEPTH), 1'b0, 32'h0);
        request(32'h0000_0002, 1'b1, 32'hFFFF_FFFF);
        request(32'(4 * DEPTH), 1'b1, 32'hFFFF_FFFF);
        request(32'h0000_0000, 1'b0, 32'h0);
        request(32'h0000_0004, 1'b0, 32'h0);

        repeat (25) applyStimulus(1'b1, randAddr(), 1'($urandom_range(0, 1)), $urandom);

        request(32'h0000_0008, 1'b1, 32'hCAFE_F00D);
        doReset(2);
        request(32'h0000_0008, 1'b0, 32'h0);

        repeat (300) applyStimulus(1'($urandom_range(0, 9) < 7), randAddr(), 1'($urandom_range(0, 1)), $urandom);

        repeat (LAT + 4) applyStimulus(1'b0, randAddr(), 1'b0, $urandom);
        checkOutput("pendingAtEnd", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024; number of 32-bit words in the backing array, power of two, 16 to 65536.
REQ-002 Parameter LATENCY, default 1; extra wait cycles before a response, 0 to 15.
REQ-003 Port clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port mem_addr_valid  input  1  initiator request strobe.
REQ-006 Port mem_addr  input  32  byte address of the request.
REQ-007 Port mem_data_valid  input  1  high together with mem_addr_valid to mark the request as a write.
REQ-008 Port mem_data  input  32  write data.
REQ-009 Port mem_ready  output  1  one-cycle response strobe.
REQ-010 Port mem_input  output  32  response data returned to the initiator.
REQ-011 Port mem_error  output  1  qualifies mem_ready; high when the request was rejected.
REQ-012 Port busy  output  1  high whenever state is not IDLE.
REQ-013 Port req_count  output  32  number of completed responses.

Function
REQ-014 The block SHALL implement three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with mem_addr_valid=1 at a rising edge, the block SHALL accept the request on that edge:
- latch mem_addr, mem_data and we=mem_data_valid;
- go to RESP if LATENCY=0;
- otherwise go to WAIT and load cnt with LATENCY-1.
REQ-016 In WAIT, the block SHALL go to RESP when cnt=0 and otherwise decrement cnt.
REQ-017 For a request accepted at edge k, mem_ready SHALL be high for exactly the one cycle following edge k+LATENCY.
REQ-018 mem_error SHALL be driven together with mem_ready and SHALL be 0 whenever mem_ready=0.
REQ-019 From RESP, the block SHALL return to IDLE unconditionally on the next edge.
REQ-020 mem_addr_valid sampled during WAIT or RESP SHALL be ignored, so back-to-back requests are spaced at least LATENCY+2 cycles apart.
REQ-021 Changes on any request input after acceptance SHALL have no effect on the pending request.
REQ-022 Word index SHALL be latched mem_addr[31:2]; latched mem_addr[1:0] other than 0 SHALL be treated as misaligned.
REQ-023 Index >= DEPTH_WORDS SHALL be treated as out of range.
REQ-024 On the edge that enters RESP with a valid request, the block SHALL:
- for a write: write the latched mem_data to the indexed word and set mem_input to the written data;
- for a read: set mem_input to the indexed word.
REQ-025 On the edge that enters RESP with a misaligned or out-of-range request, the block SHALL set mem_input=0, set mem_error=1 and SHALL NOT modify the array.
REQ-026 mem_input SHALL hold its value until the next response.
REQ-027 A read following a write to the same word SHALL return the written data.
REQ-028 req_count SHALL increment by 1 on every edge that enters RESP, errors included, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-029 busy SHALL equal (state != IDLE), registered with the state.
REQ-030 An edge where mem_addr_valid=0 in IDLE SHALL leave all outputs unchanged except that mem_ready and mem_error remain 0.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set state=IDLE, cnt=0, mem_ready=0, mem_error=0, mem_input=0, req_count=0 and busy=0.
REQ-032 Reset SHALL take priority over every other event at that edge.
REQ-033 Reset during WAIT SHALL abort the pending request: no write, no mem_ready.
REQ-034 Reset SHALL NOT clear array contents.
REQ-035 Request inputs seen while reset=1 SHALL be ignored; the first acceptance is possible at the first edge with reset=0.

Verification
REQ-036 LATENCY=1, read of word 0x4 preloaded with 0xDEADBEEF, accepted at edge k -> mem_ready=1 only after edge k+1, mem_input=0xDEADBEEF, mem_error=0, req_count=1.
REQ-037 LATENCY=0, write 0x12345678 to 0x10, then read 0x10 -> each response follows its accepting edge by one cycle; read returns 0x12345678.
REQ-038 Read 0x2 (misaligned) and read 4*DEPTH_WORDS (out of range) -> mem_error=1 with mem_ready, mem_input=0, array unchanged, req_count advances by 2.
REQ-039 LATENCY=3, mem_addr_valid held high continuously with changing addresses -> acceptance every 5 cycles, each response uses the address captured at its acceptance, busy high for 4 cycles per request.
REQ-040 LATENCY=4, write accepted, reset asserted in WAIT -> no mem_ready, target word keeps its old value, all outputs 0, next request after reset served normally.
REQ-041 req_count forced near wrap by running 2^32 responses in an accelerated bench or a formal check -> count goes 0xFFFFFFFF to 0.
